// File: rtl/capi_res_mgr_mc.sv
// Tag pool manager: hands out tags from a free-list FIFO to several channels under
// per-channel outstanding limits, and takes them back through a two-stage checked free path.
module capi_res_mgr_mc #(
  parameter int id_width  = 4,
  parameter int channels  = 4,
  parameter bit tag_check = 1'b1,
  localparam int ch_width = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [channels-1:0]                i_req_v,
  input  logic [channels*(id_width+1)-1:0]   i_limit,
  output logic [channels-1:0]                o_gnt_v,
  output logic [id_width-1:0]                o_gnt_id,
  input  logic                               i_free_v,
  input  logic [id_width-1:0]                i_free_id,
  input  logic [ch_width-1:0]                i_free_ch,
  output logic                               o_free_err,
  output logic                               o_owner_err,
  output logic [channels*(id_width+1)-1:0]   o_cnt,
  output logic                               o_init_done,
  output logic                               o_idle
);

  localparam int num_res = 1 << id_width;
  localparam int cw      = id_width + 1;

  // Handshake: i_req_v is a level; each o_gnt_v pulse hands out exactly one tag, and a
  // requester still high in the grant cycle is re-arbitrated from the following cycle.
  // i_free_v is a one-cycle strobe with no back-pressure; rejected frees only pulse an error.

  logic [id_width-1:0] mem [num_res];
  logic [ch_width-1:0] owner [num_res];
  logic [num_res-1:0]  in_use;
  logic [id_width-1:0] rd_ptr, wr_ptr;
  logic [cw-1:0]       fifo_cnt, init_cnt;
  logic                init_done;
  logic [cw-1:0]       cnt_q [channels];
  logic [channels-1:0] gnt_q;
  logic [id_width-1:0] gnt_id_q;
  logic [ch_width-1:0] rr_ptr;
  logic                f1_v;
  logic [id_width-1:0] f1_id;
  logic [ch_width-1:0] f1_ch;
  logic                free_err_q, owner_err_q;

  logic                fifo_empty, fifo_full, init_load, push_any;
  logic [id_width-1:0] push_data, head_id;
  logic [channels-1:0] eligible, cnt_inc, cnt_dec;
  logic                win_v;
  logic [ch_width-1:0] win_ch;
  logic                f_free_err, f_owner_err, f_accept;
  logic                all_zero;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == cw'(num_res));
  assign init_load  = !init_done && (init_cnt != cw'(num_res));
  assign head_id    = mem[rd_ptr];

  always_comb begin
    eligible = '0;
    for (int c = 0; c < channels; c++) begin
      eligible[c] = init_done && i_req_v[c] && !fifo_empty && !gnt_q[c] &&
                    (cnt_q[c] < i_limit[c*cw +: cw]);
    end
  end

  // Round robin: scan from rr_ptr upward first, then wrap to the channels below it.
  always_comb begin
    win_v  = 1'b0;
    win_ch = '0;
    for (int c = 0; c < channels; c++) begin
      if (!win_v && eligible[c] && (ch_width'(c) >= rr_ptr)) begin
        win_v  = 1'b1;
        win_ch = ch_width'(c);
      end
    end
    for (int c = 0; c < channels; c++) begin
      if (!win_v && eligible[c] && (ch_width'(c) < rr_ptr)) begin
        win_v  = 1'b1;
        win_ch = ch_width'(c);
      end
    end
  end

  // Stage 2 of the free path: judge the registered free against the in-use/owner table.
  always_comb begin
    f_free_err  = 1'b0;
    f_owner_err = 1'b0;
    f_accept    = 1'b0;
    if (tag_check) begin
      if (f1_v && !in_use[f1_id])            f_free_err  = 1'b1;
      else if (f1_v && owner[f1_id] != f1_ch) f_owner_err = 1'b1;
      else if (f1_v)                          f_accept    = !fifo_full;
    end else begin
      f_accept = f1_v && init_done && !fifo_full;
    end
  end

  assign push_any  = init_load || f_accept;
  assign push_data = init_load ? init_cnt[id_width-1:0] : f1_id;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int c = 0; c < channels; c++) begin
      cnt_inc[c] = win_v && (win_ch == ch_width'(c));
      cnt_dec[c] = f_accept && (f1_ch == ch_width'(c)) && (cnt_q[c] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt    <= '0;
      init_done   <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      rr_ptr      <= '0;
      in_use      <= '0;
      f1_v        <= 1'b0;
      f1_id       <= '0;
      f1_ch       <= '0;
      free_err_q  <= 1'b0;
      owner_err_q <= 1'b0;
      for (int c = 0; c < channels; c++) cnt_q[c] <= '0;
    end else begin
      if (init_load) init_cnt <= init_cnt + 1'b1;
      if (init_cnt == cw'(num_res)) init_done <= 1'b1;
      for (int c = 0; c < channels; c++) begin
        gnt_q[c] <= cnt_inc[c];
        if (cnt_inc[c] && !cnt_dec[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
        else if (cnt_dec[c] && !cnt_inc[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
      end
      if (win_v) begin
        gnt_id_q <= head_id;
        rd_ptr   <= rd_ptr + 1'b1;
        rr_ptr   <= (int'(win_ch) == channels - 1) ? '0 : win_ch + 1'b1;
      end
      if (push_any) wr_ptr <= wr_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + cw'(push_any) - cw'(win_v);
      if (f_accept) in_use[f1_id] <= 1'b0;
      if (win_v)    in_use[head_id] <= 1'b1;
      f1_v        <= i_free_v;
      f1_id       <= i_free_id;
      f1_ch       <= i_free_ch;
      free_err_q  <= f_free_err;
      owner_err_q <= f_owner_err;
    end
  end

  always_ff @(posedge clk) begin
    if (push_any) mem[wr_ptr] <= push_data;
    if (win_v)    owner[head_id] <= win_ch;
  end

  always_comb begin
    o_cnt    = '0;
    all_zero = 1'b1;
    for (int c = 0; c < channels; c++) begin
      o_cnt[c*cw +: cw] = cnt_q[c];
      if (cnt_q[c] != '0) all_zero = 1'b0;
    end
  end

  assign o_gnt_v     = gnt_q;
  assign o_gnt_id    = gnt_id_q;
  assign o_free_err  = free_err_q;
  assign o_owner_err = owner_err_q;
  assign o_init_done = init_done;
  assign o_idle      = init_done && all_zero;

endmodule

// File: tb/tb_capi_res_mgr_mc.sv
// Bench for capi_res_mgr_mc: queue-based reference model predicts grants, error pulses and
// counts; a negedge monitor pops the expectations and compares them with the DUT.
module tb_capi_res_mgr_mc;

  localparam int IW  = 4;
  localparam int CH  = 4;
  localparam int CW  = IW + 1;
  localparam int NR  = 1 << IW;
  localparam int CHW = 2;
  localparam int GW  = 32 + CH + IW;
  localparam int EW  = 34;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     req = '0;
  logic [CH*CW-1:0]  limit = '0;
  logic              free_v = 1'b0;
  logic [IW-1:0]     free_id = '0;
  logic [CHW-1:0]    free_ch = '0;
  logic [CH-1:0]     o_gnt_v;
  logic [IW-1:0]     o_gnt_id;
  logic              o_free_err, o_owner_err, o_init_done, o_idle;
  logic [CH*CW-1:0]  o_cnt;

  always #5 clk = ~clk;

  capi_res_mgr_mc #(.id_width(IW), .channels(CH), .tag_check(1'b1)) dut (
    .clk(clk), .reset(reset), .i_req_v(req), .i_limit(limit),
    .o_gnt_v(o_gnt_v), .o_gnt_id(o_gnt_id),
    .i_free_v(free_v), .i_free_id(free_id), .i_free_ch(free_ch),
    .o_free_err(o_free_err), .o_owner_err(o_owner_err),
    .o_cnt(o_cnt), .o_init_done(o_init_done), .o_idle(o_idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model state: the free list is a plain queue of tag numbers.
  int m_fl[$];
  int m_init_n;
  bit m_init_done;
  int m_cnt[CH];
  bit m_in_use[NR];
  int m_owner[NR];
  int m_rr;
  int m_gprev;
  bit m_f1_v;
  int m_f1_id, m_f1_ch;

  logic [GW-1:0] exp_gnt_q[$];
  logic [EW-1:0] exp_err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
    for (int c = 0; c < CH; c++) s += m_cnt[c];
    return s;
  endfunction

  always @(posedge clk) begin : ref_model
    int win, c, id;
    bit ferr, oerr, acc;
    cyc++;
    mon_en = 1'b1;
    if (reset) begin
      m_fl.delete();
      m_init_n = 0;
      m_init_done = 1'b0;
      for (int k = 0; k < CH; k++) m_cnt[k] = 0;
      for (int k = 0; k < NR; k++) m_in_use[k] = 1'b0;
      m_rr = 0;
      m_gprev = -1;
      m_f1_v = 1'b0;
    end else begin
      win = -1;
      if (m_init_done && m_fl.size() > 0) begin
        for (int k = 0; k < CH; k++) begin
          c = (m_rr + k) % CH;
          if (win < 0 && req[c] && m_cnt[c] < int'(limit[c*CW +: CW]) && c != m_gprev) win = c;
        end
      end
      ferr = 1'b0; oerr = 1'b0; acc = 1'b0;
      if (m_f1_v) begin
        if (!m_in_use[m_f1_id])                ferr = 1'b1;
        else if (m_owner[m_f1_id] != m_f1_ch)  oerr = 1'b1;
        else                                   acc  = 1'b1;
      end
      if (win >= 0) begin
        id = m_fl.pop_front();
        exp_gnt_q.push_back({32'(cyc), CH'(1) << win, IW'(id)});
        m_cnt[win]++;
        m_in_use[id] = 1'b1;
        m_owner[id] = win;
        m_rr = (win + 1) % CH;
      end
      m_gprev = win;
      if (acc) begin
        m_fl.push_back(m_f1_id);
        m_cnt[m_f1_ch]--;
        m_in_use[m_f1_id] = 1'b0;
      end
      if (ferr) exp_err_q.push_back({32'(cyc), 2'b01});
      if (oerr) exp_err_q.push_back({32'(cyc), 2'b10});
      if (!m_init_done) begin
        if (m_init_n == NR) m_init_done = 1'b1;
        else begin
          m_fl.push_back(m_init_n);
          m_init_n++;
        end
      end
      m_f1_v  = free_v;
      m_f1_id = int'(free_id);
      m_f1_ch = int'(free_ch);
    end
  end

  always @(negedge clk) begin : monitor
    logic [GW-1:0] ge;
    logic [EW-1:0] ee;
    logic [CH*CW-1:0] ec;
    if (mon_en) begin
      if (exp_gnt_q.size() > 0 && exp_gnt_q[0][GW-1 -: 32] == 32'(cyc)) begin
        ge = exp_gnt_q.pop_front();
        check("gnt_v", 64'(o_gnt_v), 64'(ge[IW +: CH]));
        check("gnt_id", 64'(o_gnt_id), 64'(ge[IW-1:0]));
      end else begin
        check("gnt_v_idle", 64'(o_gnt_v), 64'd0);
      end
      if (exp_err_q.size() > 0 && exp_err_q[0][EW-1 -: 32] == 32'(cyc)) begin
        ee = exp_err_q.pop_front();
        check("err_pulse", 64'({o_owner_err, o_free_err}), 64'(ee[1:0]));
      end else begin
        check("err_idle", 64'({o_owner_err, o_free_err}), 64'd0);
      end
      for (int c = 0; c < CH; c++) ec[c*CW +: CW] = CW'(m_cnt[c]);
      check("cnt", 64'(o_cnt), 64'(ec));
      check("init_done", 64'(o_init_done), 64'(m_init_done));
      check("idle", 64'(o_idle), 64'(m_init_done && m_sum() == 0));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [CH-1:0] rq);
    int n;
    @(negedge clk);
    reset = 1'b1; free_v = 1'b0; req = rq;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (o_init_done === 1'b1) break;
    end
    check("init_latency", 64'(n), 64'd17);
  endtask

  task automatic free_tag(input int id, input int ch);
    @(negedge clk);
    free_v = 1'b1; free_id = IW'(id); free_ch = CHW'(ch);
    @(negedge clk);
    free_v = 1'b0;
  endtask

  // Strobe one free and report after how many cycles the next grant appears (-1: none in 6).
  task automatic free_latency(input int id, input int ch, output int d);
    @(negedge clk);
    free_v = 1'b1; free_id = IW'(id); free_ch = CHW'(ch);
    d = -1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (d < 0 && o_gnt_v !== '0) d = n;
      @(negedge clk);
      free_v = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d, o, s, t, r, dut_sum;
    bit hit, found;
    limit = {CH{5'd16}};

    // Full pool drained round robin by four requesters.
    do_reset(4'b1111);
    wait_cycles(25);
    check("all_out_4_each", 64'(o_cnt), 64'({CH{5'd4}}));

    // One tag returned while only channel 0 requests.
    req = 4'b0001;
    wait_cycles(2);
    free_latency(9, m_owner[9], d);
    check("free9_to_gnt_cycles", 64'(d), 64'd3);
    check("free9_gnt_id", 64'(o_gnt_id), 64'd9);
    req = '0;
    wait_cycles(2);
    for (int id = 0; id < NR; id++)
      if (m_in_use[id]) free_tag(id, m_owner[id]);
    wait_cycles(4);
    check("idle_after_all_free", 64'(o_idle), 64'd1);

    // Double free and wrong-owner free.
    req = 4'b1111;
    wait_cycles(25);
    req = '0;
    wait_cycles(2);
    o = m_owner[5];
    free_tag(5, o);
    wait_cycles(3);
    free_tag(5, o);
    wait_cycles(3);
    o = m_owner[3];
    free_tag(3, (o + 2) % CH);
    wait_cycles(4);

    // Channel 1 capped at two outstanding tags.
    limit = '0;
    limit[CW +: CW] = 5'd2;
    do_reset(4'b0010);
    wait_cycles(10);
    check("ch1_capped", 64'(o_cnt[CW +: CW]), 64'd2);
    free_latency(0, 1, d);
    check("ch1_regrant_cycles", 64'(d), 64'd3);

    // Reset with seven tags outstanding.
    limit = {CH{5'd16}};
    do_reset(4'b1111);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (m_sum() == 7) hit = 1'b1;
    end
    dut_sum = 0;
    for (int c = 0; c < CH; c++) dut_sum += int'(o_cnt[c*CW +: CW]);
    check("seven_outstanding", 64'(dut_sum), 64'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    check("cnt_cleared_on_reset", 64'(o_cnt), 64'd0);
    do_reset(4'b1111);
    wait_cycles(5);
    req = '0;

    // Randomized traffic, with one mid-run reset and a free during initialisation.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(negedge clk);
        reset = 1'b1; free_v = 1'b0; req = CH'($urandom);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        free_v = 1'b1; free_id = IW'($urandom_range(0, NR-1)); free_ch = CHW'($urandom_range(0, CH-1));
      end
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) req = CH'($urandom);
      if ($urandom_range(0, 63) == 0)
        for (int c = 0; c < CH; c++) limit[c*CW +: CW] = CW'($urandom_range(0, 16));
      r = $urandom_range(0, 9);
      free_v = 1'b0;
      if (r < 4) begin
        s = $urandom_range(0, NR-1);
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          t = (s + k) % NR;
          if (!found && m_in_use[t]) begin
            found = 1'b1;
            free_v = 1'b1;
            free_id = IW'(t);
            free_ch = CHW'(($urandom_range(0, 7) == 0) ? (m_owner[t] + 1) % CH : m_owner[t]);
          end
        end
      end else if (r == 4) begin
        free_v = 1'b1;
        free_id = IW'($urandom_range(0, NR-1));
        free_ch = CHW'($urandom_range(0, CH-1));
      end
    end
    @(negedge clk);
    free_v = 1'b0;
    req = '0;
    wait_cycles(10);
    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("err_queue_drained", 64'(exp_err_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
